// File: rtl/if_axis_tx.sv
// CPU-writable byte FIFO drained onto an 8-bit AXI-Stream master.
// A small register window provides TXDATA push, STATUS and CTRL.
module if_axis_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hE4000000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        axis_aclk_i,
    input  logic        axis_aresetn_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        data_w_i,
    output logic [31:0] data_o,
    output logic        data_access_o,
    input  logic        m_axis_tready_i,
    output logic        m_axis_tvalid_o,
    output logic [7:0]  m_axis_tdata_o
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [5:0]            OFF_TXDATA = 6'h00;
    localparam logic [5:0]            OFF_STATUS = 6'h01;
    localparam logic [5:0]            OFF_CTRL   = 6'h02;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovf;
    logic                  r_en;
    logic                  r_lock;
    logic [31:0]           r_data;

    logic        w_hit;
    logic [5:0]  w_offset;
    logic        w_empty;
    logic        w_full;
    logic        w_valid;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_overflow;
    logic        w_ctrl_wr;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    assign w_hit         = (addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_offset      = addr_i[7:2];
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == FULL_COUNT);
    assign w_unused_bits = &{1'b0, addr_i[1:0], data_i[31:8]};

    // r_lock keeps a presented beat valid after en is cleared, until it is taken.
    assign w_valid    = (r_en | r_lock) & ~w_empty;
    assign w_pop      = w_valid & m_axis_tready_i;
    assign w_push_req = w_hit & data_w_i & (w_offset == OFF_TXDATA);
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_overflow = w_push_req & w_full & ~w_pop;
    assign w_ctrl_wr  = w_hit & data_w_i & (w_offset == OFF_CTRL);

    assign data_access_o   = w_hit;
    assign data_o          = r_data;
    assign m_axis_tvalid_o = w_valid;
    assign m_axis_tdata_o  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

    always_comb begin
        w_status                     = '0;
        w_status[0]                  = w_empty;
        w_status[1]                  = w_full;
        w_status[2]                  = r_ovf;
        w_status[8 +: DEPTH_LOG2+1]  = r_count;
    end

    always_comb begin
        w_rdata = '0;
        case (w_offset)
            OFF_STATUS: w_rdata = w_status;
            OFF_CTRL:   w_rdata = {31'd0, r_en};
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge axis_aclk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i[7:0];
        end
    end

    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A new overflow wins over a clear on the same edge.
    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            r_ovf  <= 1'b0;
            r_en   <= 1'b0;
            r_lock <= 1'b0;
        end else begin
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end else if (w_ctrl_wr && data_i[1]) begin
                r_ovf <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_en <= data_i[0];
            end
            r_lock <= w_valid & ~w_pop;
        end
    end

    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            r_data <= '0;
        end else if (w_hit && !data_w_i) begin
            r_data <= w_rdata;
        end
    end

endmodule

// File: tb/tb_if_axis_tx.sv
// Testbench for if_axis_tx: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_if_axis_tx;

    localparam logic [31:0] BASE  = 32'hE4000000;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_CT  = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;
    localparam logic [31:0] A_OUT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic        dataW = 1'b0;
    logic        tready = 1'b0;
    logic [31:0] data_o;
    logic        access;
    logic        tvalid;
    logic [7:0]  tdata;

    int errors = 0;
    int checks = 0;

    // Reference model: byte queue plus control flags
    logic [7:0]  mq[$];
    logic        mEn = 1'b0;
    logic        mOvf = 1'b0;
    logic        mShown = 1'b0;
    logic [31:0] mDataO = '0;
    logic [7:0]  beats[$];
    logic [7:0]  sent[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        rdy;
        logic        expAccess;
        logic        expValid;
        logic [7:0]  expData;
        logic [31:0] expDataO;
    } vec_t;

    vec_t vecs[13];

    if_axis_tx #(.BASE_ADDR(BASE), .DEPTH_LOG2(4)) dut (
        .axis_aclk_i     (clk),
        .axis_aresetn_i  (rst_n),
        .addr_i          (addr),
        .data_i          (data),
        .data_w_i        (dataW),
        .data_o          (data_o),
        .data_access_o   (access),
        .m_axis_tready_i (tready),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tdata_o  (tdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic modelValid();
        return (mq.size() != 0) && (mEn || mShown);
    endfunction

    function automatic logic [7:0] modelHead();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    function automatic logic [31:0] modelRead(input logic [5:0] off);
        int n;
        n = mq.size();
        case (off)
            6'h01: return (32'(n) << 8) | (32'(mOvf) << 2) | (32'(n == 16) << 1) | 32'(n == 0);
            6'h02: return 32'(mEn);
            default: return 32'h0;
        endcase
    endfunction

    function automatic void modelClear();
        mq.delete();
        mEn = 1'b0;
        mOvf = 1'b0;
        mShown = 1'b0;
        mDataO = '0;
    endfunction

    function automatic void modelEdge();
        logic hit, vld, pop, full, ovfSet;
        logic [5:0] off;
        hit = (addr[31:8] == BASE[31:8]);
        off = addr[7:2];
        vld = modelValid();
        pop = vld && tready;
        full = (mq.size() == 16);
        ovfSet = 1'b0;
        if (hit && !dataW) mDataO = modelRead(off);
        if (pop) void'(mq.pop_front());
        if (hit && dataW && off == 6'h00) begin
            if (!full || pop) mq.push_back(data[7:0]);
            else ovfSet = 1'b1;
        end
        if (hit && dataW && off == 6'h02) begin
            mEn = data[0];
            if (data[1]) mOvf = 1'b0;
        end
        if (ovfSet) mOvf = 1'b1;
        mShown = vld && !pop;
    endfunction

    // One clock: drive, check window decode, capture beat, advance model and DUT, compare.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic wr, input logic rdy);
        addr = a;
        data = d;
        dataW = wr;
        tready = rdy;
        #1;
        checkOutput("access", 32'(access), 32'(a[31:8] == BASE[31:8]));
        if (tvalid && rdy) beats.push_back(tdata);
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("tvalid", 32'(tvalid), 32'(modelValid()));
        checkOutput("tdata", 32'(tdata), 32'(modelHead()));
        checkOutput("data_o", data_o, mDataO);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        addr = A_OUT;
        data = '0;
        dataW = 1'b0;
        tready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_tvalid", 32'(tvalid), 32'h0);
        checkOutput("rst_tdata", 32'(tdata), 32'h0);
        checkOutput("rst_data_o", data_o, 32'h0);
        modelClear();
        beats.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{A_CT,  32'h1,        1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0};
        vecs[1]  = '{A_TX,  32'h41,       1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 32'h0};
        vecs[2]  = '{A_TX,  32'h42,       1'b1, 1'b1, 1'b1, 1'b1, 8'h42, 32'h0};
        vecs[3]  = '{A_TX,  32'h43,       1'b1, 1'b1, 1'b1, 1'b1, 8'h43, 32'h0};
        vecs[4]  = '{A_ST,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h100};
        vecs[5]  = '{A_ST,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h1};
        vecs[6]  = '{A_CT,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h1};
        vecs[7]  = '{32'hE4000104, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h1};
        vecs[8]  = '{A_TX,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0};
        vecs[9]  = '{A_CT,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h1};
        vecs[10] = '{A_RSV, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0};
        vecs[11] = '{A_TX,  32'hFFFFFF5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 32'h0};
        vecs[12] = '{A_ST,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 32'h100};

        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_access", i), 32'(access), 32'(vecs[i].expAccess));
            checkOutput($sformatf("vec%0d_tvalid", i), 32'(tvalid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_tdata", i), 32'(tdata), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_data_o", i), data_o, vecs[i].expDataO);
        end

        // 17 writes into a 16-deep FIFO with the stream disabled
        doReset();
        for (int i = 0; i <= 16; i++) applyStimulus(A_TX, 32'(i), 1'b1, 1'b0);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b0);
        checkOutput("overflow_status", data_o, 32'h00001006);
        applyStimulus(A_CT, 32'h1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(A_OUT, 32'h0, 1'b0, 1'b1);
        checkOutput("overflow_beats", 32'(beats.size()), 32'd16);
        for (int i = 0; i < 16 && i < beats.size(); i++)
            checkOutput($sformatf("overflow_beat%0d", i), 32'(beats[i]), 32'(i));
        applyStimulus(A_CT, 32'h3, 1'b1, 1'b1);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b1);
        checkOutput("ovf_clr_status", data_o, 32'h00000001);
        applyStimulus(A_CT, 32'h0, 1'b0, 1'b1);
        checkOutput("ctrl_readback", data_o, 32'h00000001);

        // Clearing en while a beat is presented must not withdraw it
        doReset();
        applyStimulus(A_CT, 32'h1, 1'b1, 1'b0);
        applyStimulus(A_TX, 32'h55, 1'b1, 1'b0);
        applyStimulus(A_TX, 32'h66, 1'b1, 1'b0);
        applyStimulus(A_CT, 32'h0, 1'b1, 1'b0);
        checkOutput("hold_tvalid", 32'(tvalid), 32'h1);
        checkOutput("hold_tdata", 32'(tdata), 32'h55);
        for (int i = 0; i < 3; i++) applyStimulus(A_OUT, 32'h0, 1'b0, 1'b0);
        checkOutput("hold_tvalid_late", 32'(tvalid), 32'h1);
        checkOutput("hold_tdata_late", 32'(tdata), 32'h55);
        applyStimulus(A_OUT, 32'h0, 1'b0, 1'b1);
        checkOutput("hold_after_pop", 32'(tvalid), 32'h0);
        checkOutput("hold_pop_count", 32'(beats.size()), 32'd1);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b1);
        checkOutput("hold_status", data_o, 32'h00000100);

        // Write to a full FIFO on the same edge as a pop
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(A_TX, 32'(8'hA0 + i), 1'b1, 1'b0);
        applyStimulus(A_CT, 32'h1, 1'b1, 1'b0);
        applyStimulus(A_TX, 32'hAA, 1'b1, 1'b1);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b0);
        checkOutput("full_pushpop_status", data_o, 32'h00001002);

        // Alternating push/pop for 20 bytes so the pointers wrap
        doReset();
        sent.delete();
        applyStimulus(A_CT, 32'h1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            sent.push_back(b);
            applyStimulus(A_TX, {24'($urandom), b}, 1'b1, 1'b0);
            applyStimulus(A_OUT, 32'h0, 1'b0, 1'b1);
        end
        checkOutput("wrap_beats", 32'(beats.size()), 32'd20);
        for (int i = 0; i < 20 && i < beats.size(); i++)
            checkOutput($sformatf("wrap_beat%0d", i), 32'(beats[i]), 32'(sent[i]));

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic        wr;
            int          sel;
            sel = $urandom_range(0, 9);
            wr = 1'b0;
            case (sel)
                0, 1, 2, 3: begin a = A_TX; wr = ($urandom_range(0, 9) < 8); end
                4:          a = A_ST;
                5:          begin a = A_CT; wr = ($urandom_range(0, 3) != 0); end
                6:          a = A_RSV;
                7:          a = BASE + 32'($urandom_range(4, 63) << 2);
                8:          a = 32'hE4000100 + 32'($urandom_range(0, 255));
                default:    a = $urandom;
            endcase
            a[1:0] = 2'($urandom);
            applyStimulus(a, $urandom, wr, ($urandom_range(0, 99) < 40));
        end

        // Asynchronous reset with bytes queued and a beat presented
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(A_TX, 32'(8'h30 + i), 1'b1, 1'b0);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b0);
        checkOutput("pre_reset_status", data_o, 32'h00000800);
        applyStimulus(A_CT, 32'h1, 1'b1, 1'b0);
        checkOutput("pre_reset_tvalid", 32'(tvalid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_tvalid", 32'(tvalid), 32'h0);
        checkOutput("async_tdata", 32'(tdata), 32'h0);
        checkOutput("async_data_o", data_o, 32'h0);
        modelClear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(A_RSV, 32'h0, 1'b0, 1'b1);
        checkOutput("post_reset_rsv", data_o, 32'h0);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b1);
        checkOutput("post_reset_status", data_o, 32'h00000001);
        applyStimulus(A_TX, 32'h77, 1'b1, 1'b1);
        applyStimulus(A_ST, 32'h0, 1'b0, 1'b0);
        checkOutput("post_reset_push", data_o, 32'h00000100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
